multi_cycle_ctrl: RTL and testbench

Control FSM for the team's multi-cycle MIPS datapath, in which one shared memory serves both instruction fetch and data access. The block decodes the opcode latched in the instruction register, sequences the datapath through fetch, decode, execute, memory and writeback steps, and stalls on a memory ready handshake. It drives every datapath mux select and write enable, and reports illegal opcodes.

---
 rtl/multi_cycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath with a shared instruction/data memory.
// Optional performance counters are built only when MCC_PERF_CNT_EN is defined.
module multi_cycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [5:0]  instr_op_i,
  input  logic        mem_ready_i,
  input  logic        zero_i,
  output logic        pc_write_o,
  output logic        pc_write_cond_o,
  output logic        branch_type_o,
  output logic [1:0]  pc_source_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        ir_write_o,
  output logic        reg_dst_o,
  output logic        memto_reg_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic        illegal_o,
  output logic [3:0]  state_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] retired_cnt_o
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC_R   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_EXEC_I   = 4'd9;
  localparam logic [3:0] S_I_WB     = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  logic [3:0] state_q, state_d;

  // The branch decision itself is made in the datapath; the flag is only carried here.
  logic unused_zero;
  assign unused_zero = zero_i;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves a latch.
    state_d = S_FETCH;
    unique case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (instr_op_i)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_RTYPE:       state_d = S_EXEC_R;
          OP_ADDI:        state_d = S_EXEC_I;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_I_WB;
      S_I_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_type_o   = 1'b0;
    pc_source_o     = 2'b00;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    memto_reg_o     = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = 3'b000;
    illegal_o       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        illegal_o   = !(instr_op_i inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW,
                                           OP_BEQ, OP_BNE, OP_J});
      end
      S_MEM_ADDR, S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o = 1'b1;
        memto_reg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 3'b010;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_I_WB: reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = 3'b001;
        pc_source_o     = 2'b01;
        pc_write_cond_o = 1'b1;
        branch_type_o   = (instr_op_i == OP_BNE);
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = 2'b10;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

`ifdef MCC_PERF_CNT_EN
  logic        retire;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retired_cnt_q, retired_cnt_d;

  assign retire = (state_q == S_MEM_WB) || (state_q == S_R_WB) ||
                  (state_q == S_I_WB)   || (state_q == S_BRANCH) ||
                  (state_q == S_JUMP)   || ((state_q == S_MEM_WR) && mem_ready_i);

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + 32'd1;
    retired_cnt_d = retired_cnt_q + {31'd0, retire};
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign retired_cnt_o = retired_cnt_q;
`else
  assign cycle_cnt_o   = '0;
  assign retired_cnt_o = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multi_cycle_ctrl;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                         S_MEM_ADDR = 4'd3, S_MEM_RD = 4'd4, S_MEM_WB = 4'd5,
                         S_MEM_WR = 4'd6, S_EXEC_R = 4'd7, S_R_WB = 4'd8,
                         S_EXEC_I = 4'd9, S_I_WB = 4'd10, S_BRANCH = 4'd11,
                         S_JUMP = 4'd12;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_type;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
  } out_t;

  typedef struct {
    out_t  v;
    string tag;
  } exp_item_t;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  instr_op_i = 6'h00;
  logic        mem_ready_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        pc_write_o, pc_write_cond_o, branch_type_o;
  logic [1:0]  pc_source_o;
  logic        iord_o, mem_read_o, mem_write_o, ir_write_o;
  logic        reg_dst_o, memto_reg_o, reg_write_o, alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [2:0]  alu_op_o;
  logic        illegal_o;
  logic [3:0]  state_o;
  logic [31:0] cycle_cnt_o, retired_cnt_o;

  int passed = 0;
  int total  = 0;
  exp_item_t sb_q[$];

  multi_cycle_ctrl dut (
    .clk_i(clk_i), .rst_n(rst_n), .instr_op_i(instr_op_i),
    .mem_ready_i(mem_ready_i), .zero_i(zero_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
    .branch_type_o(branch_type_o), .pc_source_o(pc_source_o),
    .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o), .memto_reg_o(memto_reg_o),
    .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .illegal_o(illegal_o),
    .state_o(state_o), .cycle_cnt_o(cycle_cnt_o), .retired_cnt_o(retired_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Hand-written expected output vector for each state of the control table.
  function automatic out_t exp_v(input logic [3:0] st, input logic rdy,
                                 input logic bt, input logic ill);
    out_t e;
    e = '0;
    e.state = st;
    case (st)
      S_FETCH:    begin e.mem_read = 1'b1; e.alu_src_b = 2'b01;
                        e.ir_write = rdy; e.pc_write = rdy; end
      S_DECODE:   begin e.alu_src_b = 2'b11; e.illegal = ill; end
      S_MEM_ADDR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      S_MEM_RD:   begin e.mem_read = 1'b1; e.iord = 1'b1; end
      S_MEM_WB:   begin e.reg_write = 1'b1; e.memto_reg = 1'b1; end
      S_MEM_WR:   begin e.mem_write = 1'b1; e.iord = 1'b1; end
      S_EXEC_R:   begin e.alu_src_a = 1'b1; e.alu_op = 3'b010; end
      S_R_WB:     begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      S_EXEC_I:   begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      S_I_WB:     e.reg_write = 1'b1;
      S_BRANCH:   begin e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_source = 2'b01;
                        e.pc_write_cond = 1'b1; e.branch_type = bt; end
      S_JUMP:     begin e.pc_write = 1'b1; e.pc_source = 2'b10; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock cycle: drive inputs, queue what the DUT must show this cycle, advance.
  task automatic step(input logic [5:0] op, input logic rdy, input logic zero,
                      input logic [3:0] st, input logic bt, input logic ill,
                      input string tag);
    exp_item_t it;
    instr_op_i  = op;
    mem_ready_i = rdy;
    zero_i      = zero;
    it.v   = exp_v(st, rdy, bt, ill);
    it.tag = tag;
    sb_q.push_back(it);
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (sb_q.size() > 0) begin
      exp_item_t it;
      out_t act;
      it  = sb_q.pop_front();
      act = '{state_o, pc_write_o, pc_write_cond_o, branch_type_o, pc_source_o,
              iord_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o, memto_reg_o,
              reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o};
      check(it.tag, {9'd0, act}, {9'd0, it.v});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    step(6'h00, 1'b1, 1'b0, S_IDLE, 1'b0, 1'b0, "reset_outputs");
    check("reset_cycle_cnt", cycle_cnt_o, 32'd0);
    check("reset_retired_cnt", retired_cnt_o, 32'd0);
    rst_n = 1'b1;

    // R-type with zero-wait memory
    step(6'h00, 1'b1, 1'b0, S_IDLE,   1'b0, 1'b0, "r_idle");
    step(6'h00, 1'b1, 1'b0, S_FETCH,  1'b0, 1'b0, "r_fetch");
    step(6'h00, 1'b1, 1'b0, S_DECODE, 1'b0, 1'b0, "r_decode");
    step(6'h00, 1'b1, 1'b0, S_EXEC_R, 1'b0, 1'b0, "r_exec");
    step(6'h00, 1'b1, 1'b0, S_R_WB,   1'b0, 1'b0, "r_wb");

    // lw with two wait states in MEM_RD
    step(6'h23, 1'b1, 1'b0, S_FETCH,    1'b0, 1'b0, "lw_fetch");
    step(6'h23, 1'b1, 1'b0, S_DECODE,   1'b0, 1'b0, "lw_decode");
    step(6'h23, 1'b1, 1'b0, S_MEM_ADDR, 1'b0, 1'b0, "lw_addr");
    step(6'h23, 1'b0, 1'b0, S_MEM_RD,   1'b0, 1'b0, "lw_rd_wait1");
    step(6'h23, 1'b0, 1'b0, S_MEM_RD,   1'b0, 1'b0, "lw_rd_wait2");
    step(6'h23, 1'b1, 1'b0, S_MEM_RD,   1'b0, 1'b0, "lw_rd_ready");
    step(6'h23, 1'b0, 1'b0, S_MEM_WB,   1'b0, 1'b0, "lw_wb_ready_ignored");

    // FETCH stall on addi
    step(6'h08, 1'b0, 1'b0, S_FETCH,  1'b0, 1'b0, "stall_fetch1");
    step(6'h08, 1'b0, 1'b0, S_FETCH,  1'b0, 1'b0, "stall_fetch2");
    step(6'h08, 1'b0, 1'b0, S_FETCH,  1'b0, 1'b0, "stall_fetch3");
    step(6'h08, 1'b1, 1'b0, S_FETCH,  1'b0, 1'b0, "stall_fetch_go");
    step(6'h08, 1'b1, 1'b0, S_DECODE, 1'b0, 1'b0, "addi_decode");
    step(6'h08, 1'b1, 1'b0, S_EXEC_I, 1'b0, 1'b0, "addi_exec");
    step(6'h08, 1'b1, 1'b0, S_I_WB,   1'b0, 1'b0, "addi_wb");

    // bne, then beq
    step(6'h05, 1'b1, 1'b0, S_FETCH,  1'b0, 1'b0, "bne_fetch");
    step(6'h05, 1'b1, 1'b0, S_DECODE, 1'b0, 1'b0, "bne_decode");
    step(6'h05, 1'b1, 1'b0, S_BRANCH, 1'b1, 1'b0, "bne_branch");
    step(6'h04, 1'b1, 1'b1, S_FETCH,  1'b0, 1'b0, "beq_fetch");
    step(6'h04, 1'b1, 1'b1, S_DECODE, 1'b0, 1'b0, "beq_decode");
    step(6'h04, 1'b1, 1'b1, S_BRANCH, 1'b0, 1'b0, "beq_branch");

    // j, then illegal opcode
    step(6'h02, 1'b1, 1'b0, S_FETCH,  1'b0, 1'b0, "j_fetch");
    step(6'h02, 1'b1, 1'b0, S_DECODE, 1'b0, 1'b0, "j_decode");
    step(6'h02, 1'b1, 1'b0, S_JUMP,   1'b0, 1'b0, "j_jump");
    step(6'h3F, 1'b1, 1'b0, S_FETCH,  1'b0, 1'b0, "ill_fetch");
    step(6'h3F, 1'b1, 1'b0, S_DECODE, 1'b0, 1'b1, "ill_decode");
    step(6'h2B, 1'b1, 1'b0, S_FETCH,  1'b0, 1'b0, "ill_back_to_fetch");

    // sw with one wait state, then a second sw aborted by reset in MEM_WR
    step(6'h2B, 1'b1, 1'b0, S_DECODE,   1'b0, 1'b0, "sw_decode");
    step(6'h2B, 1'b1, 1'b0, S_MEM_ADDR, 1'b0, 1'b0, "sw_addr");
    step(6'h2B, 1'b0, 1'b0, S_MEM_WR,   1'b0, 1'b0, "sw_wr_wait");
    step(6'h2B, 1'b1, 1'b0, S_MEM_WR,   1'b0, 1'b0, "sw_wr_ready");
    step(6'h2B, 1'b1, 1'b0, S_FETCH,    1'b0, 1'b0, "sw2_fetch");
    step(6'h2B, 1'b1, 1'b0, S_DECODE,   1'b0, 1'b0, "sw2_decode");
    step(6'h2B, 1'b1, 1'b0, S_MEM_ADDR, 1'b0, 1'b0, "sw2_addr");
    mem_ready_i = 1'b0;
    #1;
    check("abort_pre_mem_write", {31'd0, mem_write_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_write", {31'd0, mem_write_o}, 32'd0);
    check("abort_state", {28'd0, state_o}, 32'd0);
    check("abort_cycle_cnt", cycle_cnt_o, 32'd0);
    @(posedge clk_i);
    #1;
    step(6'h02, 1'b1, 1'b0, S_IDLE, 1'b0, 1'b0, "abort_reset_hold");
    rst_n = 1'b1;

    // Counters: j, addi, sw with zero-wait memory after reset
    step(6'h02, 1'b1, 1'b0, S_IDLE,   1'b0, 1'b0, "cnt_idle");
    step(6'h02, 1'b1, 1'b0, S_FETCH,  1'b0, 1'b0, "cnt_j_fetch");
    step(6'h02, 1'b1, 1'b0, S_DECODE, 1'b0, 1'b0, "cnt_j_decode");
    step(6'h02, 1'b1, 1'b0, S_JUMP,   1'b0, 1'b0, "cnt_j_jump");
`ifdef MCC_PERF_CNT_EN
    check("cnt_after_j_retired", retired_cnt_o, 32'd1);
    check("cnt_after_j_cycles", cycle_cnt_o, 32'd4);
`else
    check("cnt_after_j_retired", retired_cnt_o, 32'd0);
    check("cnt_after_j_cycles", cycle_cnt_o, 32'd0);
`endif
    step(6'h08, 1'b1, 1'b0, S_FETCH,    1'b0, 1'b0, "cnt_addi_fetch");
    step(6'h08, 1'b1, 1'b0, S_DECODE,   1'b0, 1'b0, "cnt_addi_decode");
    step(6'h08, 1'b1, 1'b0, S_EXEC_I,   1'b0, 1'b0, "cnt_addi_exec");
    step(6'h08, 1'b1, 1'b0, S_I_WB,     1'b0, 1'b0, "cnt_addi_wb");
    step(6'h2B, 1'b1, 1'b0, S_FETCH,    1'b0, 1'b0, "cnt_sw_fetch");
    step(6'h2B, 1'b1, 1'b0, S_DECODE,   1'b0, 1'b0, "cnt_sw_decode");
    step(6'h2B, 1'b1, 1'b0, S_MEM_ADDR, 1'b0, 1'b0, "cnt_sw_addr");
    step(6'h2B, 1'b1, 1'b0, S_MEM_WR,   1'b0, 1'b0, "cnt_sw_wr");
`ifdef MCC_PERF_CNT_EN
    check("cnt_final_retired", retired_cnt_o, 32'd3);
    check("cnt_final_cycles", cycle_cnt_o, 32'd12);
`else
    check("cnt_final_retired", retired_cnt_o, 32'd0);
    check("cnt_final_cycles", cycle_cnt_o, 32'd0);
`endif
    step(6'h2B, 1'b1, 1'b0, S_FETCH, 1'b1, 1'b0, "final_fetch");

    @(negedge clk_i);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
